unified_mem_arbiter: RTL and testbench

- Shares one single-port synchronous word memory between the instruction-fetch requester (read only) and the data-access requester (read/write).
- Lets the pipelined core run with a single unified memory instead of separate instruction and data caches.
- Arbitrates each cycle, drives the memory port, and tracks in-flight reads so returned data is routed to the correct requester.
- Has bounded starvation protection for instruction fetch.

---
 rtl/pex_mem_pkg.sv | 16 +
 rtl/mem_tag_pipe.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 106 ++++++++++
 tb/tb_unified_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pex_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// port identifiers, default widths and the in-flight read tag.
package pex_mem_pkg;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic valid;
        logic port;
    } mem_tag_t;

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register of read tags; the tail entry lines up with the
// memory's read data, so it says which requester owns the returning word.
module mem_tag_pipe
    import pex_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  mem_tag_t tag_in,
    output mem_tag_t tag_out
);

    mem_tag_t [DEPTH-1:0] tags_q;
    mem_tag_t [DEPTH-1:0] tags_d;

    always_comb begin
        tags_d    = tags_q;
        tags_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            tags_d[i] = tags_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign tag_out = tags_q[DEPTH-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by instruction fetch (read only) and data access.
// Data wins contention until it has starved fetch for STARVE_LIMIT grants.
module unified_mem_arbiter
    import pex_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stat_conflicts
);

    localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [15:0]         conflicts_q, conflicts_d;
    logic                i_win;
    mem_tag_t            tag_in;
    mem_tag_t            tag_tail;

    // Byte-offset and high address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        i_win = i_req && (!d_req || (streak_q == STREAK_MAX));
        i_gnt = !rst && i_win;
        d_gnt = !rst && d_req && !i_win;

        // Only a data grant that made fetch wait extends the streak.
        streak_d = '0;
        if (i_req && d_gnt) begin
            streak_d = streak_q + 1'b1;
        end

        conflicts_d = conflicts_q;
        if (i_req && d_req && (conflicts_q != 16'hFFFF)) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    always_comb begin
        mem_en    = i_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            mem_addr  = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end

        tag_in.valid = mem_en && !mem_we;
        tag_in.port  = d_gnt ? PORT_D : PORT_I;
    end

    mem_tag_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .tag_out(tag_tail)
    );

    always_comb begin
        i_rvalid = tag_tail.valid && (tag_tail.port == PORT_I);
        d_rvalid = tag_tail.valid && (tag_tail.port == PORT_D);
        i_rdata  = rst ? '0 : mem_rdata;
        d_rdata  = rst ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q    <= '0;
            conflicts_q <= '0;
        end else begin
            streak_q    <= streak_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign stat_conflicts = conflicts_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (read latency 1, 2, 3) share
// one clock and are checked every cycle against a transaction-level model.
module tb_unified_mem_arbiter;
  import pex_mem_pkg::*;

  localparam int N     = 3;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0] i_req, i_gnt, i_rvalid;
  logic [N-1:0] d_req, d_we, d_gnt, d_rvalid;
  logic [N-1:0] mem_en, mem_we;
  logic [31:0]   i_addr[N];
  logic [31:0]   d_addr[N];
  logic [DW-1:0] d_wdata[N];
  logic [DW-1:0] i_rdata[N];
  logic [DW-1:0] d_rdata[N];
  logic [DW-1:0] mem_wdata[N];
  logic [DW-1:0] mem_rdata[N];
  logic [AW-1:0] mem_addr[N];
  logic [15:0]   stat_conflicts[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    unified_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(g + 1), .STARVE_LIMIT(LIMIT)
    ) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_gnt(i_gnt[g]),
      .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .stat_conflicts(stat_conflicts[g])
    );
  end

  // Power-on content of every memory word, so reads of untouched words are known.
  function automatic logic [31:0] init_word(input logic [11:0] w);
    return {w, 8'h5A, w};
  endfunction

  // ---------------- synchronous memory with RD_LATENCY = g+1 ----------------
  logic [DW-1:0] mem[N][4096];
  bit            written[N][4096];
  logic [DW-1:0] rd_pipe[N][4];

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (mem_en[g] && mem_we[g]) begin
        mem[g][mem_addr[g]]     <= mem_wdata[g];
        written[g][mem_addr[g]] <= 1'b1;
      end
      rd_pipe[g][0] <= (mem_en[g] && !mem_we[g])
                     ? (written[g][mem_addr[g]] ? mem[g][mem_addr[g]] : init_word(mem_addr[g]))
                     : 32'hBADBAD00;
      for (int k = 1; k < 4; k++) rd_pipe[g][k] <= rd_pipe[g][k-1];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_rd
    assign mem_rdata[g] = rd_pipe[g][g];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [DW-1:0] ref_mem[N][4096];
  bit            ref_wr[N][4096];
  int            waits[N];
  int            conf[N];
  bit            last_gi[N];
  bit            last_gd[N];
  int            cyc;
  int            n_tests;
  int            n_fail;
  // entry = {due cycle[15:0], port, data}
  logic [48:0]   exp_q[N][$];

  task automatic check(input string tag, input int g, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, g, obs, exp);
    end
  endtask

  task automatic model_cycle();
    logic [48:0] ent;
    logic        exp_iv, exp_dv, gi, gd, isw;
    logic [31:0] rdat;
    logic [11:0] wa;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        exp_q[g].delete();
        waits[g]   = 0;
        conf[g]    = 0;
        last_gi[g] = 1'b0;
        last_gd[g] = 1'b0;
        check("rst_i_gnt", g, i_gnt[g], 0);
        check("rst_d_gnt", g, d_gnt[g], 0);
        check("rst_i_rvalid", g, i_rvalid[g], 0);
        check("rst_d_rvalid", g, d_rvalid[g], 0);
        check("rst_mem_en", g, mem_en[g], 0);
        check("rst_mem_we", g, mem_we[g], 0);
        check("rst_mem_addr", g, mem_addr[g], 0);
        check("rst_mem_wdata", g, mem_wdata[g], 0);
        check("rst_i_rdata", g, i_rdata[g], 0);
        check("rst_d_rdata", g, d_rdata[g], 0);
        check("rst_conflicts", g, stat_conflicts[g], 0);
      end else begin
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        rdat   = '0;
        if (exp_q[g].size() > 0) begin
          ent = exp_q[g][0];
          if (ent[48:33] == 16'(cyc)) begin
            void'(exp_q[g].pop_front());
            exp_iv = (ent[32] == PORT_I);
            exp_dv = (ent[32] == PORT_D);
            rdat   = ent[31:0];
          end
        end
        check("i_rvalid", g, i_rvalid[g], exp_iv);
        check("d_rvalid", g, d_rvalid[g], exp_dv);
        if (exp_iv) check("i_rdata", g, i_rdata[g], rdat);
        if (exp_dv) check("d_rdata", g, d_rdata[g], rdat);
        check("conflicts", g, stat_conflicts[g], 32'(conf[g]));

        gi = i_req[g] && (!d_req[g] || waits[g] == LIMIT);
        gd = d_req[g] && !gi;
        check("i_gnt", g, i_gnt[g], gi);
        check("d_gnt", g, d_gnt[g], gd);
        check("mem_en", g, mem_en[g], gi | gd);
        isw = gd && d_we[g];
        check("mem_we", g, mem_we[g], isw);
        if (gi || gd) begin
          wa = gd ? d_addr[g][13:2] : i_addr[g][13:2];
          check("mem_addr", g, mem_addr[g], wa);
          if (isw) begin
            check("mem_wdata", g, mem_wdata[g], d_wdata[g]);
            ref_mem[g][wa] = d_wdata[g];
            ref_wr[g][wa]  = 1'b1;
          end else begin
            exp_q[g].push_back({16'(cyc + g + 1), gd,
                                ref_wr[g][wa] ? ref_mem[g][wa] : init_word(wa)});
          end
        end
        waits[g] = (i_req[g] && gd) ? waits[g] + 1 : 0;
        if (i_req[g] && d_req[g] && conf[g] < 65535) conf[g]++;
        last_gi[g] = gi;
        last_gd[g] = gd;
      end
    end
    cyc++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_cycle();
      nxt();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a       = $urandom;
    a[13:2] = 12'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b1;
    i_req   = '1;
    d_req   = '1;
    d_we    = '0;
    for (int g = 0; g < N; g++) begin
      i_addr[g]  = 32'h40;
      d_addr[g]  = 32'h44;
      d_wdata[g] = '0;
      waits[g]   = 0;
      conf[g]    = 0;
    end

    // Reset with both requests high, then first grant after release.
    model_cycle();
    check("reset_mem_en", 0, mem_en[0], 0);
    check("reset_conflicts", 0, stat_conflicts[0], 0);
    nxt();
    rst = 1'b0;
    model_cycle();
    for (int g = 0; g < N; g++) check("first_gnt_d", g, d_gnt[g], 1);
    nxt();
    d_req = '0;
    step(1);
    i_req = '0;
    step(4);

    // Instruction read at latency 1.
    i_req[0] = 1'b1;
    i_addr[0] = 32'h10;
    model_cycle();
    check("ifetch_gnt", 0, i_gnt[0], 1);
    check("ifetch_addr", 0, mem_addr[0], 4);
    nxt();
    i_req[0] = 1'b0;
    model_cycle();
    check("ifetch_rvalid", 0, i_rvalid[0], 1);
    check("ifetch_rdata", 0, i_rdata[0], init_word(12'd4));
    nxt();

    // Data write, then read-back of the same word.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'hDEADBEEF;
    model_cycle();
    check("wr_gnt", 0, d_gnt[0], 1);
    check("wr_mem_we", 0, mem_we[0], 1);
    check("wr_mem_addr", 0, mem_addr[0], 8);
    nxt();
    d_we[0] = 1'b0;
    model_cycle();
    check("wr_no_rvalid", 0, d_rvalid[0], 0);
    nxt();
    d_req[0] = 1'b0;
    model_cycle();
    check("rd_back_rvalid", 0, d_rvalid[0], 1);
    check("rd_back_data", 0, d_rdata[0], 32'hDEADBEEF);
    nxt();
    step(3);

    // Continuous contention after a fresh reset: D,D,D,D,I repeating.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    i_req[1] = 1'b1; i_addr[1] = 32'h100;
    d_req[1] = 1'b1; d_addr[1] = 32'h104; d_we[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      model_cycle();
      check("contention_i_gnt", 1, i_gnt[1], (k % 5 == 4));
      nxt();
    end
    i_req[1] = 1'b0;
    d_req[1] = 1'b0;
    model_cycle();
    check("contention_count", 1, stat_conflicts[1], 20);
    nxt();
    step(4);

    // Latency 3: alternating I/D reads of words 0..3, returns in order.
    for (int t = 0; t < 8; t++) begin
      i_req[2] = 1'b0;
      d_req[2] = 1'b0;
      if (t < 4) begin
        if (t % 2 == 0) begin i_req[2] = 1'b1; i_addr[2] = 32'(4 * t); end
        else begin d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'(4 * t); end
      end
      model_cycle();
      if (t >= 3 && t <= 6) begin
        check("lat3_i_rvalid", 2, i_rvalid[2], ((t - 3) % 2 == 0));
        check("lat3_d_rvalid", 2, d_rvalid[2], ((t - 3) % 2 == 1));
        check("lat3_rdata", 2, ((t - 3) % 2 == 0) ? i_rdata[2] : d_rdata[2],
              init_word(12'(t - 3)));
      end
      nxt();
    end

    // Reset the cycle after a latency-2 read grant: the read never returns.
    i_req[1] = 1'b1;
    i_addr[1] = 32'h30;
    step(1);
    i_req[1] = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      model_cycle();
      check("no_rvalid_after_rst", 1, i_rvalid[1], 0);
      nxt();
    end

    // Randomized traffic on all instances; requests held until granted.
    for (int it = 0; it < 600; it++) begin
      for (int g = 0; g < N; g++) begin
        if (!i_req[g] || last_gi[g]) begin
          i_req[g] = ($urandom_range(0, 99) < 60);
          i_addr[g] = rand_addr();
        end
        if (!d_req[g] || last_gd[g]) begin
          d_req[g]   = ($urandom_range(0, 99) < 60);
          d_we[g]    = ($urandom_range(0, 99) < 40);
          d_addr[g]  = rand_addr();
          d_wdata[g] = $urandom;
        end
      end
      step(1);
    end
    i_req = '0;
    d_req = '0;
    step(6);
    for (int g = 0; g < N; g++) check("queue_drained", g, exp_q[g].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
